// File: rtl/sio_target_link.sv
// Target-side link layer for the serial remote-IO protocol.
// Deframes 29-nibble host frames (start, addr, data, stream, crc16-usb),
// strobes good frames to register logic, then returns an 18-cycle reply
// after TURN cycles and ignores the line for GUARD cycles afterwards.
// Optional build macro SIO_NAK_EN: a CRC-failed frame is answered with a
// NAK reply (data 0, status 4'hE) instead of being silently dropped.
//
// state  | meaning
// S_IDLE | line idle, waiting for start nibble 4'h0
// S_RX   | shifting in the 28 post-start nibbles
// S_TURN | turnaround before driving the reply
// S_TX   | driving preamble, start, data, stream, crc
// S_GUARD| line released, rx still ignored
module sio_target_link #(
  parameter int unsigned TURN  = 4,
  parameter int unsigned GUARD = 2
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic [3:0]  rd_i,
  output logic [3:0]  td_o,
  output logic        tq_o,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [63:0] wr_data_o,
  output logic [15:0] rx_stream_o,
  output logic        crc_err_o,
  output logic        frame_err_o,
  input  logic [31:0] rd_data_i,
  input  logic [11:0] tx_stream_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_TURN, S_TX, S_GUARD} state_t;

  state_t        state_q, state_d;
  logic [4:0]    rx_cnt_q;
  logic [111:0]  asm_q;
  logic [15:0]   rx_crc_q;
  logic [7:0]    wait_cnt_q;
  logic [4:0]    tx_cnt_q;
  logic [47:0]   tx_sh_q;
  logic [15:0]   tx_crc_q;
  logic          wr_valid_q, crc_err_q, frame_err_q;
  logic [15:0]   wr_addr_q, rx_stream_q;
  logic [63:0]   wr_data_q;
`ifdef SIO_NAK_EN
  logic          nak_q;
`endif

  logic [111:0]  asm_full;
  logic          rx_last, crc_ok, wait_done, tx_last;

  // Reflected crc16 (poly 0x8005, LSB-first) advanced by one nibble.
  function automatic logic [15:0] crc_nib(input logic [15:0] crc, input logic [3:0] nib);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ 16'hA001;
      else               c = c >> 1;
    end
    return c;
  endfunction

  // The received crc is the top 16 bits once the final nibble is included.
  assign asm_full  = {rd_i, asm_q[111:4]};
  assign rx_last   = (state_q == S_RX) && (rx_cnt_q == 5'd27);
  assign crc_ok    = (asm_full[111:96] == rx_crc_q);
  assign wait_done = (wait_cnt_q == 8'd0);
  assign tx_last   = (state_q == S_TX) && (tx_cnt_q == 5'd17);

  assign wr_valid_o  = wr_valid_q;
  assign crc_err_o   = crc_err_q;
  assign frame_err_o = frame_err_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rx_stream_o = rx_stream_q;

  // State register.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and line driver outputs.
  always_comb begin
    state_d = state_q;
    td_o    = 4'hF;
    tq_o    = 1'b1;
    busy_o  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (rd_i == 4'h0) state_d = S_RX;
      S_RX: begin
        if (rx_last) begin
`ifdef SIO_NAK_EN
          state_d = S_TURN;
`else
          state_d = crc_ok ? S_TURN : S_GUARD;
`endif
        end
      end
      S_TURN:  if (wait_done) state_d = S_TX;
      S_TX: begin
        tq_o = 1'b0;
        if (tx_cnt_q == 5'd0)       td_o = 4'hF;
        else if (tx_cnt_q == 5'd1)  td_o = 4'h0;
        else if (tx_cnt_q <= 5'd13) td_o = tx_sh_q[3:0];
        else                        td_o = tx_crc_q[3:0];
        if (tx_last) state_d = S_GUARD;
      end
      S_GUARD: if (wait_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Deframing, strobes, wait timers and reply shifter.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rx_cnt_q    <= '0;
      asm_q       <= '0;
      rx_crc_q    <= 16'hFFFF;
      wait_cnt_q  <= '0;
      tx_cnt_q    <= '0;
      tx_sh_q     <= '0;
      tx_crc_q    <= 16'hFFFF;
      wr_valid_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rx_stream_q <= '0;
`ifdef SIO_NAK_EN
      nak_q       <= 1'b0;
`endif
    end else begin
      wr_valid_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          rx_crc_q <= 16'hFFFF;
          if (rd_i != 4'h0 && rd_i != 4'hF) frame_err_q <= 1'b1;
        end
        S_RX: begin
          asm_q    <= asm_full;
          rx_cnt_q <= rx_cnt_q + 5'd1;
          // addr, data and stream[11:0] are the first 23 nibbles
          if (rx_cnt_q < 5'd23) rx_crc_q <= crc_nib(rx_crc_q, rd_i);
          if (rx_last) begin
            if (crc_ok) begin
              wr_valid_q  <= 1'b1;
              wr_addr_q   <= asm_full[15:0];
              wr_data_q   <= asm_full[79:16];
              rx_stream_q <= asm_full[95:80];
              wait_cnt_q  <= 8'(TURN - 1);
`ifdef SIO_NAK_EN
              nak_q       <= 1'b0;
`endif
            end else begin
              crc_err_q   <= 1'b1;
`ifdef SIO_NAK_EN
              nak_q       <= 1'b1;
              wait_cnt_q  <= 8'(TURN - 1);
`else
              wait_cnt_q  <= 8'(GUARD - 1);
`endif
            end
          end
        end
        S_TURN: begin
          tx_cnt_q <= '0;
          if (!wait_done) wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        S_TX: begin
          tx_cnt_q <= tx_cnt_q + 5'd1;
          if (tx_cnt_q == 5'd0) begin
            tx_crc_q <= 16'hFFFF;
`ifdef SIO_NAK_EN
            tx_sh_q  <= nak_q ? {4'hE, tx_stream_i, 32'h0} : {4'h0, tx_stream_i, rd_data_i};
`else
            tx_sh_q  <= {4'h0, tx_stream_i, rd_data_i};
`endif
          end else if (tx_cnt_q >= 5'd2 && tx_cnt_q <= 5'd13) begin
            tx_sh_q <= tx_sh_q >> 4;
            // status nibble (count 13) is outside the reply crc
            if (tx_cnt_q <= 5'd12) tx_crc_q <= crc_nib(tx_crc_q, tx_sh_q[3:0]);
          end else if (tx_cnt_q >= 5'd14) begin
            tx_crc_q <= tx_crc_q >> 4;
          end
          if (tx_last) wait_cnt_q <= 8'(GUARD - 1);
        end
        S_GUARD: begin
          if (!wait_done) wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
